// File: rtl/sprite_pkg.sv
// Shared geometry and colour definitions for the 20x20 sprite memories.
package sprite_pkg;

   localparam int SPRITE_W     = 20;
   localparam int SPRITE_H     = 20;
   localparam int SPRITE_DEPTH = SPRITE_W * SPRITE_H;
   localparam int COLOUR_W     = 9;
   localparam int ADDR_W       = 9;
   localparam int COORD_W      = 5;

   typedef logic [COLOUR_W-1:0] colour_t;

endpackage

// File: rtl/sprite_addr_translate.sv
// Tile-coordinate to linear-address translation, shared by all 20x20 sprite memories.
module sprite_addr_translate
   import sprite_pkg::*;
#(
   parameter int SPRITE_W = sprite_pkg::SPRITE_W,
   parameter int SPRITE_H = sprite_pkg::SPRITE_H,
   parameter int ADDR_W   = sprite_pkg::ADDR_W
) (
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output logic [ADDR_W-1:0]  mem_address,
   output logic               addr_valid
);

   logic [ADDR_W-1:0] x_ext;
   logic [ADDR_W-1:0] y_ext;
   logic [ADDR_W-1:0] linear;

   assign x_ext  = ADDR_W'(x);
   assign y_ext  = ADDR_W'(y);
   assign linear = ADDR_W'(y_ext * ADDR_W'(SPRITE_W)) + x_ext;

   assign addr_valid = (32'(x) < SPRITE_W) && (32'(y) < SPRITE_H);

   // Out-of-tile coordinates park the address at 0 so downstream never indexes past the array.
   assign mem_address = addr_valid ? linear : '0;

endmodule

// File: rtl/tower_sprite_rom.sv
// Tower sprite memory: 20x20 colour words, coordinate addressed, registered read, optional write.
module tower_sprite_rom
   import sprite_pkg::*;
#(
   parameter int    SPRITE_W  = sprite_pkg::SPRITE_W,
   parameter int    SPRITE_H  = sprite_pkg::SPRITE_H,
   parameter int    COLOUR_W  = sprite_pkg::COLOUR_W,
   parameter int    ADDR_W    = sprite_pkg::ADDR_W,
   parameter string INIT_FILE = "tower.mif"
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [4:0]          x,
   input  logic [4:0]          y,
   input  logic [COLOUR_W-1:0] data,
   input  logic                wren,
   output logic [ADDR_W-1:0]   mem_address,
   output logic                addr_valid,
   output logic [COLOUR_W-1:0] q
);

   localparam int DEPTH = SPRITE_W * SPRITE_H;

   // Contents come from the image at configuration; reset never touches the array.
   (* ram_init_file = INIT_FILE *) logic [COLOUR_W-1:0] mem [0:DEPTH-1];

   sprite_addr_translate #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H),
      .ADDR_W   (ADDR_W)
   ) u_translate (
      .x           (x),
      .y           (y),
      .mem_address (mem_address),
      .addr_valid  (addr_valid)
   );

   always_ff @(posedge clk) begin
      if (resetn && wren && addr_valid) begin
         mem[mem_address] <= data;
      end
   end

   // Same-edge read sees the pre-write word (read-before-write).
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         q <= '0;
      end else if (addr_valid) begin
         q <= mem[mem_address];
      end else begin
         q <= '0;
      end
   end

endmodule

// File: tb/tb_tower_sprite_rom.sv
// Scoreboard bench for tower_sprite_rom: model memory predicts q, compared one edge later.
module tb_tower_sprite_rom;

   logic       clk;
   logic       resetn;
   logic [4:0] x;
   logic [4:0] y;
   logic [8:0] data;
   logic       wren;
   logic [8:0] mem_address;
   logic       addr_valid;
   logic [8:0] q;

   typedef struct {
      logic       chk;
      logic [8:0] val;
      string      name;
   } exp_t;

   exp_t       sb[$];
   logic [8:0] model [0:399];
   int         errors = 0;
   int         checks = 0;

   tower_sprite_rom dut (
      .clk         (clk),
      .resetn      (resetn),
      .x           (x),
      .y           (y),
      .data        (data),
      .wren        (wren),
      .mem_address (mem_address),
      .addr_valid  (addr_valid),
      .q           (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: predict q from the model at the current inputs, apply any write, compare after the edge.
   task automatic cycle(input logic chk, input string name);
      exp_t e;
      int   a;
      logic v;
      v = (x < 20) && (y < 20);
      a = int'(y) * 20 + int'(x);
      e.chk  = chk;
      e.name = name;
      if (!resetn || !v) e.val = 9'd0;
      else               e.val = model[a];
      if (resetn && wren && v) model[a] = data;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (e.chk) begin
         checks++;
         if (q !== e.val) begin
            errors++;
            $display("FAIL %s: q=%h expected %h", e.name, q, e.val);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      x = 0; y = 0; data = 0; wren = 0;
      #2;
      checks++;
      if (q !== 9'd0) begin
         errors++;
         $display("FAIL reset_q: q=%h expected 000", q);
      end
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_translation();
      int pts[4][3] = '{'{0, 0, 0}, '{19, 0, 19}, '{0, 1, 20}, '{19, 19, 399}};
      for (int i = 0; i < 4; i++) begin
         x = 5'(pts[i][0]);
         y = 5'(pts[i][1]);
         #1;
         checks++;
         if (mem_address !== 9'(pts[i][2]) || addr_valid !== 1'b1) begin
            errors++;
            $display("FAIL translate(%0d,%0d): addr=%0d valid=%b expected addr=%0d valid=1",
                     pts[i][0], pts[i][1], mem_address, addr_valid, pts[i][2]);
         end
      end
   endtask

   // Loads word k = k through the write port so the rest of the bench has a known image.
   task automatic preload();
      for (int k = 0; k < 400; k++) begin
         x = 5'(k % 20);
         y = 5'(k / 20);
         data = 9'(k);
         wren = 1'b1;
         cycle(1'b0, "preload");
      end
      wren = 1'b0;
   endtask

   task automatic test_init_latency();
      x = 0; y = 0;
      cycle(1'b1, "read_word0");
      x = 3; y = 2;
      #1;
      checks++;
      if (q !== 9'd0) begin
         errors++;
         $display("FAIL latency_hold: q=%h expected 000 before edge", q);
      end
      cycle(1'b1, "read_3_2");
      checks++;
      if (q !== 9'd43) begin
         errors++;
         $display("FAIL init_3_2: q=%0d expected 43", q);
      end
   endtask

   task automatic test_write_read();
      x = 5; y = 7; data = 9'h1A5; wren = 1'b1;
      cycle(1'b1, "write_1a5_old");
      wren = 1'b0;
      cycle(1'b1, "read_1a5");
   endtask

   task automatic test_read_before_write();
      x = 5; y = 7; data = 9'h0F0; wren = 1'b1;
      cycle(1'b1, "rbw_old");
      checks++;
      if (q !== 9'h1A5) begin
         errors++;
         $display("FAIL rbw_old_const: q=%h expected 1a5", q);
      end
      wren = 1'b0;
      cycle(1'b1, "rbw_new");
      checks++;
      if (q !== 9'h0F0) begin
         errors++;
         $display("FAIL rbw_new_const: q=%h expected 0f0", q);
      end
   endtask

   task automatic test_out_of_range();
      int pts[2][2] = '{'{20, 0}, '{0, 20}};
      for (int i = 0; i < 2; i++) begin
         x = 5'(pts[i][0]);
         y = 5'(pts[i][1]);
         data = 9'h1FF;
         wren = 1'b1;
         #1;
         checks++;
         if (addr_valid !== 1'b0 || mem_address !== 9'd0) begin
            errors++;
            $display("FAIL oor(%0d,%0d): addr=%0d valid=%b expected addr=0 valid=0",
                     pts[i][0], pts[i][1], mem_address, addr_valid);
         end
         cycle(1'b1, "oor_q");
      end
      wren = 1'b0;
      x = 0; y = 0;
      cycle(1'b1, "oor_word0_kept");
   endtask

   task automatic test_reset_midscan();
      x = 5; y = 7;
      cycle(1'b1, "pre_reset_read");
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if (q !== 9'd0) begin
         errors++;
         $display("FAIL async_reset: q=%h expected 000", q);
      end
      @(negedge clk);
      data = 9'h155; wren = 1'b1;
      cycle(1'b1, "in_reset_q");
      wren = 1'b0;
      resetn = 1'b1;
      cycle(1'b1, "after_reset_keeps_0f0");
   endtask

   initial begin
      x = 0; y = 0; data = 0; wren = 0; resetn = 1'b1;
      @(negedge clk);
      test_reset();
      test_translation();
      preload();
      test_init_latency();
      test_write_read();
      test_read_before_write();
      test_out_of_range();
      test_reset_midscan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
